// File: rtl/core_arb_pkg.sv
// Shared types for the core memory-port arbiter.
package core_arb_pkg;

    // Requester that owns a granted transaction.
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_LSU   = 1'b1
    } owner_e;

    // Lock state: a request presented to the bridge but not yet accepted.
    typedef enum logic [1:0] {
        LockNone  = 2'd0,
        LockInstr = 2'd1,
        LockLsu   = 2'd2
    } lock_e;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/arb_owner_fifo.sv
// Records the owner of every granted-but-unanswered transaction, in issue order.
module arb_owner_fifo
    import core_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    owner_e          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= OWNER_INSTR;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_owner;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU,
// routing in-order responses back to whichever side issued each transaction.
module core_mem_arbiter
    import core_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ARB_MODE        = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    busy_o,
    output logic                    proto_err_o
);

    logic   any_req;
    logic   issue;
    logic   accept;
    logic   resp;
    logic   fifo_full;
    logic   fifo_empty;
    owner_e head;
    owner_e sel;
    owner_e rr_last_q;
    lock_e  lock_q;
    lock_e  lock_d;
    logic   proto_err_q;

    assign any_req = instr_req_i | lsu_req_i;
    // A full owner FIFO blocks issue even if a response frees a slot this cycle.
    assign issue   = any_req & ~fifo_full;
    assign accept  = issue & mem_gnt_i;
    assign resp    = mem_rvalid_i & ~fifo_empty;

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= LockNone;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Lock next state: an unaccepted request pins the owner until the bridge takes it.
    always_comb begin
        lock_d = lock_q;
        if (accept) begin
            lock_d = LockNone;
        end else if (issue) begin
            lock_d = (sel == OWNER_LSU) ? LockLsu : LockInstr;
        end
    end

    // Owner selection: locked owner first, else fixed priority or round-robin.
    always_comb begin
        sel = OWNER_INSTR;
        case (lock_q)
            LockInstr: sel = OWNER_INSTR;
            LockLsu:   sel = OWNER_LSU;
            default: begin
                if (ARB_MODE == ARB_FIXED) begin
                    sel = lsu_req_i ? OWNER_LSU : OWNER_INSTR;
                end else if (instr_req_i && lsu_req_i) begin
                    sel = (rr_last_q == OWNER_LSU) ? OWNER_INSTR : OWNER_LSU;
                end else begin
                    sel = lsu_req_i ? OWNER_LSU : OWNER_INSTR;
                end
            end
        endcase
    end

    // Round-robin history moves only when a grant actually happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= OWNER_LSU;
        end else if (accept) begin
            rr_last_q <= sel;
        end
    end

    // Request field mux; fetches are full-word reads. Fields idle at zero.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (issue) begin
            if (sel == OWNER_LSU) begin
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign mem_req_o   = issue;
    assign instr_gnt_o = accept & (sel == OWNER_INSTR);
    assign lsu_gnt_o   = accept & (sel == OWNER_LSU);

    // Responses go to the head owner; read data fans out to both sides ungated.
    assign instr_rvalid_o = resp & (head == OWNER_INSTR);
    assign lsu_rvalid_o   = resp & (head == OWNER_LSU);
    assign instr_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o    = mem_rdata_i;

    assign busy_o      = ~fifo_empty | any_req;
    assign proto_err_o = proto_err_q;

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            proto_err_q <= 1'b1;
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_owner (sel),
        .pop        (resp),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: two instances (round-robin depth 2, fixed-priority depth 3)
// checked every cycle against a queue-based model, plus directed scenarios with literal values.
module tb_core_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NI = 2;

    logic clk;
    logic rst;

    logic          instr_req    [NI];
    logic [AW-1:0] instr_addr   [NI];
    logic          instr_gnt    [NI];
    logic          instr_rvalid [NI];
    logic [DW-1:0] instr_rdata  [NI];
    logic          lsu_req      [NI];
    logic          lsu_we       [NI];
    logic [BW-1:0] lsu_be       [NI];
    logic [AW-1:0] lsu_addr     [NI];
    logic [DW-1:0] lsu_wdata    [NI];
    logic          lsu_gnt      [NI];
    logic          lsu_rvalid   [NI];
    logic [DW-1:0] lsu_rdata    [NI];
    logic          mem_req      [NI];
    logic          mem_we       [NI];
    logic [BW-1:0] mem_be       [NI];
    logic [AW-1:0] mem_addr     [NI];
    logic [DW-1:0] mem_wdata    [NI];
    logic          mem_gnt      [NI];
    logic          mem_rvalid   [NI];
    logic [DW-1:0] mem_rdata    [NI];
    logic          busy         [NI];
    logic          proto_err    [NI];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: 0 = instr, 1 = lsu.
    int oq       [NI][8];
    int ocnt     [NI];
    bit m_lock   [NI];
    int m_lown   [NI];
    int m_rr     [NI];
    bit m_err    [NI];
    bit m_ig     [NI];
    bit m_lg     [NI];

    function automatic int maxo(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int amode(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        core_mem_arbiter #(
            .ADDR_WIDTH      (AW),
            .DATA_WIDTH      (DW),
            .MAX_OUTSTANDING ((g == 0) ? 2 : 3),
            .ARB_MODE        ((g == 0) ? 0 : 1)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .instr_req_i    (instr_req[g]),
            .instr_addr_i   (instr_addr[g]),
            .instr_gnt_o    (instr_gnt[g]),
            .instr_rvalid_o (instr_rvalid[g]),
            .instr_rdata_o  (instr_rdata[g]),
            .lsu_req_i      (lsu_req[g]),
            .lsu_we_i       (lsu_we[g]),
            .lsu_be_i       (lsu_be[g]),
            .lsu_addr_i     (lsu_addr[g]),
            .lsu_wdata_i    (lsu_wdata[g]),
            .lsu_gnt_o      (lsu_gnt[g]),
            .lsu_rvalid_o   (lsu_rvalid[g]),
            .lsu_rdata_o    (lsu_rdata[g]),
            .mem_req_o      (mem_req[g]),
            .mem_we_o       (mem_we[g]),
            .mem_be_o       (mem_be[g]),
            .mem_addr_o     (mem_addr[g]),
            .mem_wdata_o    (mem_wdata[g]),
            .mem_gnt_i      (mem_gnt[g]),
            .mem_rvalid_i   (mem_rvalid[g]),
            .mem_rdata_i    (mem_rdata[g]),
            .busy_o         (busy[g]),
            .proto_err_o    (proto_err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Model of one instance for the current cycle; inputs are stable at the falling edge.
    task automatic check_inst(input int i);
        bit            full, anyr, mreq, ig, lg, irv, lrv, ebusy, eerr;
        int            sel;
        logic          ewe;
        logic [BW-1:0] ebe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        if (rst) begin
            ocnt[i]   = 0;
            m_lock[i] = 1'b0;
            m_lown[i] = 0;
            m_rr[i]   = 1;
            m_err[i]  = 1'b0;
        end
        full = (ocnt[i] == maxo(i));
        anyr = instr_req[i] || lsu_req[i];
        mreq = anyr && !full;
        if (m_lock[i])                      sel = m_lown[i];
        else if (amode(i) == 1)             sel = lsu_req[i] ? 1 : 0;
        else if (instr_req[i] && lsu_req[i]) sel = 1 - m_rr[i];
        else                                sel = lsu_req[i] ? 1 : 0;
        ig = mreq && mem_gnt[i] && (sel == 0);
        lg = mreq && mem_gnt[i] && (sel == 1);
        ewe = 1'b0; ebe = '0; eaddr = '0; ewd = '0;
        if (mreq && sel == 1) begin
            ewe = lsu_we[i]; ebe = lsu_be[i]; eaddr = lsu_addr[i]; ewd = lsu_wdata[i];
        end else if (mreq) begin
            ebe = {BW{1'b1}}; eaddr = instr_addr[i];
        end
        irv   = mem_rvalid[i] && (ocnt[i] > 0) && (oq[i][0] == 0);
        lrv   = mem_rvalid[i] && (ocnt[i] > 0) && (oq[i][0] == 1);
        ebusy = (ocnt[i] > 0) || anyr;
        eerr  = m_err[i];

        chk("mem_req", i, mem_req[i], mreq);
        chk("instr_gnt", i, instr_gnt[i], ig);
        chk("lsu_gnt", i, lsu_gnt[i], lg);
        chk("mem_we", i, mem_we[i], ewe);
        chk("mem_be", i, mem_be[i], ebe);
        chk("mem_addr", i, mem_addr[i], eaddr);
        chk("mem_wdata", i, mem_wdata[i], ewd);
        chk("instr_rvalid", i, instr_rvalid[i], irv);
        chk("lsu_rvalid", i, lsu_rvalid[i], lrv);
        chk("instr_rdata", i, instr_rdata[i], mem_rdata[i]);
        chk("lsu_rdata", i, lsu_rdata[i], mem_rdata[i]);
        chk("busy", i, busy[i], ebusy);
        chk("proto_err", i, proto_err[i], eerr);

        m_ig[i] = 1'b0;
        m_lg[i] = 1'b0;
        if (!rst) begin
            if (mem_rvalid[i]) begin
                if (ocnt[i] > 0) begin
                    for (int j = 0; j < 7; j++) oq[i][j] = oq[i][j+1];
                    ocnt[i]--;
                end else begin
                    m_err[i] = 1'b1;
                end
            end
            if (mreq && mem_gnt[i]) begin
                oq[i][ocnt[i]] = sel;
                ocnt[i]++;
                m_rr[i]   = sel;
                m_lock[i] = 1'b0;
            end else if (mreq) begin
                m_lock[i] = 1'b1;
                m_lown[i] = sel;
            end
            m_ig[i] = ig;
            m_lg[i] = lg;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) check_inst(i);
    end

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            instr_req[i] = 0; instr_addr[i] = '0;
            lsu_req[i] = 0; lsu_we[i] = 0; lsu_be[i] = '0; lsu_addr[i] = '0; lsu_wdata[i] = '0;
            mem_gnt[i] = 0; mem_rvalid[i] = 0; mem_rdata[i] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pr;
        rst = 1'b1;
        idle_all();

        // Reset state.
        @(negedge clk);
        chk("rst_mem_req", 0, mem_req[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_proto_err", 0, proto_err[0], 0);
        chk("rst_irv", 0, instr_rvalid[0], 0);

        // Fetch alone: same-cycle grant, response routed to fetch only.
        do_reset();
        step(); instr_req[0] = 1; instr_addr[0] = 32'h100; mem_gnt[0] = 1;
        @(negedge clk);
        chk("t1_igrant", 0, instr_gnt[0], 1);
        chk("t1_addr", 0, mem_addr[0], 32'h100);
        step(); instr_req[0] = 0; mem_rvalid[0] = 1; mem_rdata[0] = 32'hAAAA_0001;
        @(negedge clk);
        chk("t1_irv", 0, instr_rvalid[0], 1);
        chk("t1_lrv", 0, lsu_rvalid[0], 0);
        chk("t1_rdata", 0, instr_rdata[0], 32'hAAAA_0001);
        step(); idle_all();

        // Both requesting: alternate in round-robin, LSU always in fixed priority.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                instr_req[i] = 1; instr_addr[i] = 32'h1000 + k;
                lsu_req[i] = 1; lsu_addr[i] = 32'h2000 + k;
                mem_gnt[i] = 1; mem_rvalid[i] = (k > 0);
            end
            @(negedge clk);
            chk("t2_rr_igrant", 0, instr_gnt[0], (k % 2 == 0));
            chk("t2_rr_lgrant", 0, lsu_gnt[0], (k % 2 == 1));
            chk("t2_fix_lgrant", 1, lsu_gnt[1], 1);
            chk("t2_fix_igrant", 1, instr_gnt[1], 0);
        end
        step(); instr_req[0] = 0; lsu_req[0] = 0; lsu_req[1] = 0;
        @(negedge clk);
        chk("t2_fix_instr_after", 1, instr_gnt[1], 1);
        step(); idle_all(); mem_rvalid[1] = 1;
        step(); idle_all();

        // Lock: an unaccepted LSU request keeps the port until granted.
        do_reset();
        step(); lsu_req[0] = 1; lsu_addr[0] = 32'h200; lsu_we[0] = 1; lsu_be[0] = 4'h3;
        lsu_wdata[0] = 32'h55;
        @(negedge clk);
        chk("t3_addr0", 0, mem_addr[0], 32'h200);
        chk("t3_lgnt0", 0, lsu_gnt[0], 0);
        step(); instr_req[0] = 1; instr_addr[0] = 32'h300;
        @(negedge clk);
        chk("t3_addr1", 0, mem_addr[0], 32'h200);
        chk("t3_ignt1", 0, instr_gnt[0], 0);
        step();
        @(negedge clk);
        chk("t3_we2", 0, mem_we[0], 1);
        step(); mem_gnt[0] = 1;
        @(negedge clk);
        chk("t3_lgnt3", 0, lsu_gnt[0], 1);
        chk("t3_be3", 0, mem_be[0], 4'h3);
        step(); lsu_req[0] = 0;
        @(negedge clk);
        chk("t3_ignt4", 0, instr_gnt[0], 1);
        chk("t3_addr4", 0, mem_addr[0], 32'h300);
        chk("t3_be4", 0, mem_be[0], 4'hF);
        step(); instr_req[0] = 0; mem_gnt[0] = 0; mem_rvalid[0] = 1;
        @(negedge clk);
        chk("t3_lrv", 0, lsu_rvalid[0], 1);
        step();
        @(negedge clk);
        chk("t3_irv", 0, instr_rvalid[0], 1);
        step(); idle_all();

        // Full owner FIFO blocks issue, even in the cycle a response arrives.
        do_reset();
        step(); instr_req[0] = 1; instr_addr[0] = 32'h400; mem_gnt[0] = 1;
        step(); instr_addr[0] = 32'h404;
        step(); instr_addr[0] = 32'h408;
        @(negedge clk);
        chk("t4_full_req", 0, mem_req[0], 0);
        chk("t4_full_busy", 0, busy[0], 1);
        step(); mem_rvalid[0] = 1;
        @(negedge clk);
        chk("t4_pop_req", 0, mem_req[0], 0);
        chk("t4_pop_irv", 0, instr_rvalid[0], 1);
        step(); mem_rvalid[0] = 0;
        @(negedge clk);
        chk("t4_after_req", 0, mem_req[0], 1);
        chk("t4_after_gnt", 0, instr_gnt[0], 1);
        step(); instr_req[0] = 0; mem_rvalid[0] = 1;
        step();
        step(); idle_all();

        // In-order routing of I, L, I responses.
        do_reset();
        step(); instr_req[1] = 1; mem_gnt[1] = 1;
        step(); instr_req[1] = 0; lsu_req[1] = 1;
        step(); lsu_req[1] = 0; instr_req[1] = 1;
        step(); instr_req[1] = 0; mem_rvalid[1] = 1; mem_rdata[1] = 32'hA;
        @(negedge clk);
        chk("t5_a_irv", 1, instr_rvalid[1], 1);
        chk("t5_a_lrv", 1, lsu_rvalid[1], 0);
        chk("t5_a_data", 1, instr_rdata[1], 32'hA);
        step(); mem_rdata[1] = 32'hB;
        @(negedge clk);
        chk("t5_b_lrv", 1, lsu_rvalid[1], 1);
        chk("t5_b_irv", 1, instr_rvalid[1], 0);
        chk("t5_b_data", 1, lsu_rdata[1], 32'hB);
        step(); mem_rdata[1] = 32'hC;
        @(negedge clk);
        chk("t5_c_irv", 1, instr_rvalid[1], 1);
        step(); idle_all();

        // Stray response, sticky error, reset mid-burst, late response.
        do_reset();
        step(); mem_rvalid[0] = 1; mem_rdata[0] = 32'hDEAD;
        @(negedge clk);
        chk("t6_stray_irv", 0, instr_rvalid[0], 0);
        chk("t6_stray_lrv", 0, lsu_rvalid[0], 0);
        step(); mem_rvalid[0] = 0;
        @(negedge clk);
        chk("t6_err_set", 0, proto_err[0], 1);
        step(); step();
        @(negedge clk);
        chk("t6_err_sticky", 0, proto_err[0], 1);
        step(); instr_req[0] = 1; mem_gnt[0] = 1;
        step(); instr_req[0] = 0; lsu_req[0] = 1;
        step(); idle_all(); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", 0, mem_req[0], 0);
        chk("t6_rst_busy", 0, busy[0], 0);
        chk("t6_rst_err", 0, proto_err[0], 0);
        step(); rst = 1'b0;
        step(); mem_rvalid[0] = 1;
        @(negedge clk);
        chk("t6_late_irv", 0, instr_rvalid[0], 0);
        chk("t6_late_lrv", 0, lsu_rvalid[0], 0);
        step(); mem_rvalid[0] = 0;
        @(negedge clk);
        chk("t6_late_err", 0, proto_err[0], 1);

        // Randomized traffic; requests are held until the model says they were granted.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            pr = ((c / 500) % 2 == 1) ? 90 : 35;
            for (int i = 0; i < NI; i++) begin
                if (!(instr_req[i] && !m_ig[i])) begin
                    instr_req[i]  = ($urandom_range(99) < pr);
                    instr_addr[i] = $urandom;
                end
                if (!(lsu_req[i] && !m_lg[i])) begin
                    lsu_req[i]   = ($urandom_range(99) < pr);
                    lsu_we[i]    = 1'($urandom_range(1));
                    lsu_be[i]    = BW'($urandom);
                    lsu_addr[i]  = $urandom;
                    lsu_wdata[i] = $urandom;
                end
                mem_gnt[i]    = ($urandom_range(99) < 70);
                mem_rvalid[i] = (ocnt[i] > 0) && ($urandom_range(99) < 55);
                mem_rdata[i]  = $urandom;
            end
        end
        step(); idle_all();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
